// File: rtl/rf_arb_pkg.sv
// Shared defaults and grant encoding for the register-file write arbiter.
package rf_arb_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned NUM_REGS = 1 << REG_W;
  localparam int unsigned CNT_W    = 8;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/rf_onehot_dec.sv
// Register-id to one-hot decoder; output is all zeros when disabled.
module rf_onehot_dec #(
  parameter int unsigned IN_W = 4
) (
  input  logic                     en_i,
  input  logic [IN_W-1:0]          idx_i,
  output logic [(1 << IN_W)-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B)
// writeback. Define RF_ARB_ZERO_REG_EN to make register 0 hardwired zero.
module rf_write_arbiter #(
  parameter int unsigned DATA_W = rf_arb_pkg::DATA_W,
  parameter int unsigned REG_W  = rf_arb_pkg::REG_W,
  parameter int unsigned CNT_W  = rf_arb_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_valid,
  input  logic [REG_W-1:0]        a_reg,
  input  logic [DATA_W-1:0]       a_data,
  output logic                    a_ready,
  input  logic                    b_valid,
  input  logic [REG_W-1:0]        b_reg,
  input  logic [DATA_W-1:0]       b_data,
  output logic                    b_ready,
  output logic                    WriteReg,
  output logic [REG_W-1:0]        DstReg,
  output logic [DATA_W-1:0]       DstData,
  output logic [(1 << REG_W)-1:0] pend_mask,
  output logic [CNT_W-1:0]        conflict_cnt
);

  import rf_arb_pkg::*;

  localparam int unsigned NumRegs = 1 << REG_W;

  logic              last_gnt_q, last_gnt_d;
  logic              wr_q, wr_d;
  logic [REG_W-1:0]  dst_reg_q, dst_reg_d;
  logic [DATA_W-1:0] dst_data_q, dst_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic a_wr_ok, b_wr_ok;
  logic a_wait, b_wait;
  logic [NumRegs-1:0] dec_out, dec_a, dec_b;

`ifdef RF_ARB_ZERO_REG_EN
  // Writes to r0 still consume a grant but never reach the register file.
  assign a_wr_ok = (a_reg != '0);
  assign b_wr_ok = (b_reg != '0);
`else
  assign a_wr_ok = 1'b1;
  assign b_wr_ok = 1'b1;
`endif

  // Ties go to whichever side did not win last; readies are held low in reset.
  assign a_ready = rst_n & a_valid & (~b_valid | (last_gnt_q == GNT_B));
  assign b_ready = rst_n & b_valid & (~a_valid | (last_gnt_q == GNT_A));

  always_comb begin
    last_gnt_d = last_gnt_q;
    wr_d       = 1'b0;
    dst_reg_d  = dst_reg_q;
    dst_data_d = dst_data_q;
    cnt_d      = cnt_q;

    if (a_ready) begin
      last_gnt_d = GNT_A;
      wr_d       = a_wr_ok;
      dst_reg_d  = a_reg;
      dst_data_d = a_data;
    end else if (b_ready) begin
      last_gnt_d = GNT_B;
      wr_d       = b_wr_ok;
      dst_reg_d  = b_reg;
      dst_data_d = b_data;
    end

    if (a_valid && b_valid && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= GNT_B;
      wr_q       <= 1'b0;
      dst_reg_q  <= '0;
      dst_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      wr_q       <= wr_d;
      dst_reg_q  <= dst_reg_d;
      dst_data_q <= dst_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign WriteReg     = wr_q;
  assign DstReg       = dst_reg_q;
  assign DstData      = dst_data_q;
  assign conflict_cnt = cnt_q;

  assign a_wait = rst_n & a_valid & ~a_ready & a_wr_ok;
  assign b_wait = rst_n & b_valid & ~b_ready & b_wr_ok;

  rf_onehot_dec #(.IN_W(REG_W)) u_dec_out (
    .en_i     (wr_q),
    .idx_i    (dst_reg_q),
    .onehot_o (dec_out)
  );

  rf_onehot_dec #(.IN_W(REG_W)) u_dec_a (
    .en_i     (a_wait),
    .idx_i    (a_reg),
    .onehot_o (dec_a)
  );

  rf_onehot_dec #(.IN_W(REG_W)) u_dec_b (
    .en_i     (b_wait),
    .idx_i    (b_reg),
    .onehot_o (dec_b)
  );

  assign pend_mask = dec_out | dec_a | dec_b;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a reference model feeding an expected-write
// scoreboard; honours RF_ARB_ZERO_REG_EN the same way the design does.
module tb_rf_write_arbiter;

  typedef struct packed {
    logic        wr;
    logic [3:0]  rg;
    logic [15:0] data;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic [3:0]  a_reg, b_reg;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic [15:0] pend_mask;
  logic [7:0]  conflict_cnt;

  exp_t        sb_q[$];
  logic        m_last;
  logic        m_wr;
  logic [3:0]  m_reg;
  logic [15:0] m_data;
  logic [7:0]  m_cnt;
  int          checks;
  int          errors;

  rf_write_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_valid      (a_valid),
    .a_reg        (a_reg),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_reg        (b_reg),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .WriteReg     (WriteReg),
    .DstReg       (DstReg),
    .DstData      (DstData),
    .pend_mask    (pend_mask),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dec(input logic [3:0] r);
    return 16'(1) << r;
  endfunction

  function automatic logic zok(input logic [3:0] r);
`ifdef RF_ARB_ZERO_REG_EN
    return r != 4'd0;
`else
    return 1'b1;
`endif
  endfunction

  // Reset asserted immediately (async), checked, then released on the next falling edge.
  task automatic reset_pulse();
    rst_n   = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    chk("rst_WriteReg", WriteReg, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_pend_mask", pend_mask, 0);
    chk("rst_DstReg", DstReg, 0);
    chk("rst_DstData", DstData, 0);
    chk("rst_conflict_cnt", conflict_cnt, 0);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n   = 1'b1;
    m_last  = 1'b1;
    m_wr    = 1'b0;
    m_reg   = '0;
    m_data  = '0;
    m_cnt   = '0;
    sb_q.delete();
  endtask

  task automatic step(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                      input logic bv, input logic [3:0] br, input logic [15:0] bd,
                      output logic a_acc, output logic b_acc);
    logic        ea, eb;
    logic [15:0] ep;
    exp_t        e;
    @(negedge clk);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    #1;
    ea = av && (!bv || m_last == 1'b1);
    eb = bv && (!av || m_last == 1'b0);
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    ep = m_wr ? dec(m_reg) : 16'h0;
    if (av && !ea && zok(ar)) ep = ep | dec(ar);
    if (bv && !eb && zok(br)) ep = ep | dec(br);
    chk("pend_mask", pend_mask, ep);
    e.cnt  = (av && bv && m_cnt != 8'hFF) ? m_cnt + 8'd1 : m_cnt;
    e.wr   = 1'b0;
    e.rg   = m_reg;
    e.data = m_data;
    if (ea) begin
      e.wr = zok(ar); e.rg = ar; e.data = ad; m_last = 1'b0;
    end else if (eb) begin
      e.wr = zok(br); e.rg = br; e.data = bd; m_last = 1'b1;
    end
    sb_q.push_back(e);
    a_acc = ea;
    b_acc = eb;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    m_wr = e.wr; m_reg = e.rg; m_data = e.data; m_cnt = e.cnt;
    chk("WriteReg", WriteReg, e.wr);
    if (e.wr) begin
      chk("DstReg", DstReg, e.rg);
      chk("DstData", DstData, e.data);
    end
    chk("conflict_cnt", conflict_cnt, e.cnt);
  endtask

  initial begin
    logic        aa, ba;
    logic [15:0] ad, bd;
    checks = 0;
    errors = 0;
    a_reg = '0; a_data = '0; b_reg = '0; b_data = '0;

    // A alone after reset
    reset_pulse();
    step(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0, aa, ba);
    chk("a_alone_acc", aa, 1);
    step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, aa, ba);

    // Contention: alternating grants, fresh data after each acceptance
    reset_pulse();
    ad = 16'h0011;
    bd = 16'h0022;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'd1, ad, 1'b1, 4'd2, bd, aa, ba);
      if (aa) ad = ad + 16'h0100;
      if (ba) bd = bd + 16'h0100;
    end
    chk("contend_cnt4", conflict_cnt, 8'd4);
    step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, aa, ba);

    // Same destination from both sides
    reset_pulse();
    step(1'b1, 4'd5, 16'h1111, 1'b1, 4'd5, 16'h2222, aa, ba);
    chk("same_first_a", aa, 1);
    step(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 16'h2222, aa, ba);
    step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, aa, ba);
    chk("same_final_data", DstData, 16'h2222);

    // Counter saturation
    reset_pulse();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 4'd6, 16'(i), 1'b1, 4'd7, 16'(i + 1000), aa, ba);
    end
    chk("sat_cnt", conflict_cnt, 8'd255);

    // Reset while a write is on the port
    reset_pulse();
    step(1'b1, 4'd9, 16'hCAFE, 1'b0, 4'd0, 16'h0, aa, ba);
    #1;
    reset_pulse();
    step(1'b1, 4'd4, 16'h4444, 1'b1, 4'd8, 16'h8888, aa, ba);
    chk("post_rst_a_wins", aa, 1);

    // Register 0 target from B
    reset_pulse();
    step(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'h5A5A, aa, ba);
    step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, aa, ba);
    // Register 0 waiting behind A
    step(1'b1, 4'd2, 16'h0202, 1'b1, 4'd0, 16'h0A0A, aa, ba);
    step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, aa, ba);
    step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, aa, ba);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
